// File: rtl/number_packer.sv
// number_packer: collects COUNT numbers of WIDTH bits, one per in_valid/in_ready
// handshake, into one packed bus (slot k at [WIDTH*k +: WIDTH]).
// The bus holds the completed frame until the consumer takes it with out_ready.
// Optional feature macro: NUMBER_PACKER_FLUSH_EN adds a flush input that
// zero-pads a partial frame and presents it early.
module number_packer #(
  parameter int WIDTH = 20,
  parameter int COUNT = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_number,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef NUMBER_PACKER_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [WIDTH*COUNT-1:0]       number,
  output logic [$clog2(COUNT+1)-1:0]   count
);

  localparam int CW = $clog2(COUNT+1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          count_nxt;
  logic [WIDTH*COUNT-1:0] number_nxt;
  logic                   accept;

  // in_ready is a registered copy of "in FILL", so it only rises on the first
  // edge after reset is released; every accept therefore implies FILL.
  assign accept = in_ready & in_valid;

  // Next-state, slot write and frame-completion decisions.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    number_nxt = number;
    unique case (state)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < COUNT; k++) begin
            if (CW'(k) == count) number_nxt[k*WIDTH +: WIDTH] = in_number;
          end
          count_nxt = count + CW'(1);
          if (count == CW'(COUNT-1)) state_nxt = FULL;
        end
`ifdef NUMBER_PACKER_FLUSH_EN
        // Flush pads from the slot after any same-cycle accept; if that
        // accept already completed the frame there is nothing left to pad.
        if (in_ready && flush && (count != '0 || accept) && state_nxt == FILL) begin
          for (int k = 0; k < COUNT; k++) begin
            if (CW'(k) >= count_nxt) number_nxt[k*WIDTH +: WIDTH] = '0;
          end
          count_nxt = CW'(COUNT);
          state_nxt = FULL;
        end
`endif
      end
      FULL: begin
        // Bus is not cleared on handoff; the next frame overwrites stale slots.
        if (out_ready) begin
          state_nxt = FILL;
          count_nxt = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // State, frame storage and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      count     <= '0;
      number    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      number    <= number_nxt;
      in_ready  <= (state_nxt == FILL);
      out_valid <= (state_nxt == FULL);
    end
  end

endmodule
